// File: rtl/pon_burst_tx_gen_if.sv
// Payload stream between the payload source and the burst framer.
//   s_data  : payload word
//   s_valid : payload word valid
//   s_ready : word accepted when s_valid && s_ready
// master = payload source, slave = framer.
interface pon_burst_tx_gen_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pon_burst_tx_gen.sv
// Upstream burst-mode TX framer for the PON TX datapath (TX user clock domain).
// Cuts a continuous payload stream into periodic bursts of preamble words, an optional
// delimiter and payload slots. Between bursts the laser enable is low and the idle word is
// sent. With b2bcontrol=0 the block passes the payload straight through.
// Optional feature: define BURST_DELIM_EN to insert one DELIM_WORD between preamble and payload.
// Ports:
//   hb0_gtwiz_userclk_tx_usrclk2_int : clock
//   hb0_gtwiz_reset_tx_done_int      : asynchronous active-low reset
//   preamble/burst_length/burst_period_vio_int : run-time lengths, captured at each burst start
//   b2bcontrol   : 1 = burst mode, 0 = continuous pass-through
//   s_axis       : payload stream (slave side)
//   tx_data      : word to the GT
//   tx_burst_en  : laser/burst enable
//   burst_start  : pulse aligned to the first word of a burst on tx_data
//   underrun_cnt : payload slots filled with IDLE_WORD (saturating)
//   overrun      : sticky, a burst outlasted its period
module pon_burst_tx_gen #(
  parameter int unsigned       DATA_W        = 32,
  parameter logic [DATA_W-1:0] PREAMBLE_WORD = 32'hAAAAAAAA,
  parameter logic [DATA_W-1:0] DELIM_WORD    = 32'hB5983A1F,
  parameter logic [DATA_W-1:0] IDLE_WORD     = 32'h00000000,
  parameter int unsigned       CNT_W         = 32
) (
  input  logic                 hb0_gtwiz_userclk_tx_usrclk2_int,
  input  logic                 hb0_gtwiz_reset_tx_done_int,
  input  logic [31:0]          preamble_length_vio_int,
  input  logic [31:0]          burst_length_vio_int,
  input  logic [31:0]          burst_period_vio_int,
  input  logic                 b2bcontrol,
  pon_burst_tx_gen_if.slave    s_axis,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_burst_en,
  output logic                 burst_start,
  output logic [CNT_W-1:0]     underrun_cnt,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StPayload, StGap, StCont
`ifdef BURST_DELIM_EN
    , StDelim
`endif
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic [CNT_W-1:0]  pl_q, pl_d, bl_q, bl_d, bp_q, bp_d;
  logic              pend_q, pend_d, first_q, first_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d, bs_q, s_ready_q, s_ready_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]  urun_q, urun_d;

`ifndef BURST_DELIM_EN
  logic unused_delim;
  assign unused_delim = ^DELIM_WORD;
`endif

  function automatic logic is_burst(state_e s);
    return !(s inside {StIdle, StGap, StCont});
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pl_d      = pl_q;
    bl_d      = bl_q;
    bp_d      = bp_q;
    pend_d    = pend_q;
    first_d   = 1'b0;
    tx_data_d = IDLE_WORD;
    tx_en_d   = 1'b0;
    urun_d    = urun_q;
    ovr_d     = ovr_q;
    // Period counter free-runs modulo the captured period.
    if ((bp_q == '0) || (cnt_q == bp_q - CNT_W'(1))) cnt_d = '0;
    else                                            cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      StIdle, StGap: begin
        if (!b2bcontrol) begin
          state_d = StCont;
          pend_d  = 1'b0;
        end else if (burst_period_vio_int == '0) begin
          state_d = StIdle;
        end else if ((cnt_q == '0) || pend_q) begin
          // Burst start: this slot counts as period position 0.
          pl_d   = CNT_W'(preamble_length_vio_int);
          bl_d   = CNT_W'(burst_length_vio_int);
          bp_d   = CNT_W'(burst_period_vio_int);
          pend_d = 1'b0;
          idx_d  = '0;
          cnt_d  = (burst_period_vio_int == 32'd1) ? '0 : CNT_W'(1);
          if (preamble_length_vio_int != '0) begin
            state_d = StPreamble;
            first_d = 1'b1;
          end
`ifdef BURST_DELIM_EN
          else begin
            state_d = StDelim;
            first_d = 1'b1;
          end
`else
          else if (burst_length_vio_int != '0) begin
            state_d = StPayload;
            first_d = 1'b1;
          end
`endif
        end
      end
      StPreamble: begin
        tx_data_d = PREAMBLE_WORD;
        tx_en_d   = 1'b1;
        if (idx_q == pl_q - CNT_W'(1)) begin
          idx_d = '0;
`ifdef BURST_DELIM_EN
          state_d = StDelim;
`else
          state_d = (bl_q != '0) ? StPayload : StGap;
`endif
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
`ifdef BURST_DELIM_EN
      StDelim: begin
        tx_data_d = DELIM_WORD;
        tx_en_d   = 1'b1;
        state_d   = (bl_q != '0) ? StPayload : StGap;
      end
`endif
      StPayload: begin
        tx_en_d = 1'b1;
        if (s_axis.s_valid) begin
          tx_data_d = s_axis.s_data;
        end else if (urun_q != '1) begin
          urun_d = urun_q + CNT_W'(1);
        end
        if (idx_q == bl_q - CNT_W'(1)) begin
          idx_d   = '0;
          state_d = StGap;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      StCont: begin
        tx_en_d = 1'b1;
        if (s_axis.s_valid) tx_data_d = s_axis.s_data;
        if (b2bcontrol) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Wrap while the burst carries on: the next burst is started as soon as this one ends.
    if (is_burst(state_q) && is_burst(state_d) && (bp_q != '0) &&
        (cnt_q == bp_q - CNT_W'(1))) begin
      ovr_d  = 1'b1;
      pend_d = 1'b1;
    end
    if ((state_d == StIdle) || (state_d == StCont)) cnt_d = '0;
    s_ready_d = (state_d == StPayload) || (state_d == StCont);
  end

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_tx_done_int) begin
    if (!hb0_gtwiz_reset_tx_done_int) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      pl_q      <= '0;
      bl_q      <= '0;
      bp_q      <= '0;
      pend_q    <= 1'b0;
      first_q   <= 1'b0;
      tx_data_q <= IDLE_WORD;
      tx_en_q   <= 1'b0;
      bs_q      <= 1'b0;
      s_ready_q <= 1'b0;
      urun_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pl_q      <= pl_d;
      bl_q      <= bl_d;
      bp_q      <= bp_d;
      pend_q    <= pend_d;
      first_q   <= first_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      bs_q      <= first_q;
      s_ready_q <= s_ready_d;
      urun_q    <= urun_d;
      ovr_q     <= ovr_d;
    end
  end

  assign s_axis.s_ready = s_ready_q;
  assign tx_data        = tx_data_q;
  assign tx_burst_en    = tx_en_q;
  assign burst_start    = bs_q;
  assign underrun_cnt   = urun_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_pon_burst_tx_gen.sv
module tb_pon_burst_tx_gen;
  localparam int DW = 32;
`ifdef BURST_DELIM_EN
  localparam int DLM = 1;
`else
  localparam int DLM = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pl_v, bl_v, bp_v;
  logic          b2b;
  logic [DW-1:0] tx_data;
  logic          tx_en, bs, ovr;
  logic [31:0]   urun;

  pon_burst_tx_gen_if #(.DATA_W(DW)) pif ();

  pon_burst_tx_gen #(.DATA_W(DW)) dut (
    .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
    .hb0_gtwiz_reset_tx_done_int      (rst_n),
    .preamble_length_vio_int          (pl_v),
    .burst_length_vio_int             (bl_v),
    .burst_period_vio_int             (bp_v),
    .b2bcontrol                       (b2b),
    .s_axis                           (pif),
    .tx_data                          (tx_data),
    .tx_burst_en                      (tx_en),
    .burst_start                      (bs),
    .underrun_cnt                     (urun),
    .overrun                          (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic        bs;
    logic [31:0] urun;
    logic        ovr;
  } exp_t;

  typedef struct {
    int          pl, bl, bp, miss0, miss1, ncyc;
    logic [31:0] urun;
    logic        ovr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   n_chk = 0, n_fail = 0;
  int   cur_test = 0, cur_slot = 0;
  bit   rel = 1'b0;
  // Reference model: position within the current burst period and its captured lengths.
  int   m_pos, m_pl, m_bl, m_bp, m_len, m_per, m_urun;
  bit   m_ovr;
  int   exp_bs, obs_bs, exp_acc, obs_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (test %0d slot %0d): got 0x%08h, want 0x%08h",
               name, cur_test, cur_slot, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_burst_start", 32'(bs), 32'd0);
    check("rst_s_ready", 32'(pif.s_ready), 32'd0);
    check("rst_underrun", urun, 32'd0);
    check("rst_overrun", 32'(ovr), 32'd0);
  endtask

  task automatic reset_dut(input int pl, input int bl, input int bp);
    rst_n = 1'b0;
    b2b = 1'b1;
    pl_v = 32'(pl);
    bl_v = 32'(bl);
    bp_v = 32'(bp);
    pif.s_valid = 1'b0;
    pif.s_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    m_pos = 0; m_urun = 0; m_ovr = 1'b0;
    exp_bs = 0; obs_bs = 0; exp_acc = 0; obs_acc = 0;
    cur_slot = 0;
    rel = 1'b1;
  endtask

  // mode 0: burst-mode model; mode 1: continuous pass-through expected.
  task automatic run_slot(input int mode, input int miss0, input int miss1);
    exp_t        e;
    exp_t        got;
    logic        v;
    logic [31:0] d;
    bit          pay;
    int          k;
    @(negedge clk);
    if (rel) begin
      rst_n = 1'b1;
      rel = 1'b0;
    end
    d = 32'h5A00_0000 + 32'(cur_slot);
    e.data = 32'h0; e.en = 1'b0; e.bs = 1'b0;
    if (mode == 0) begin
      if (m_pos == 0) begin
        m_pl = int'(pl_v); m_bl = int'(bl_v); m_bp = int'(bp_v);
        m_len = m_pl + DLM + m_bl;
        m_per = (m_len >= m_bp) ? m_len + 1 : m_bp;
      end
      k = m_pos - 1 - m_pl - DLM;
      pay = (k >= 0) && (k < m_bl);
      v = !(pay && (k == miss0 || k == miss1));
      if (m_pos >= 1 && m_pos <= m_pl) begin
        e.en = 1'b1; e.data = 32'hAAAAAAAA;
      end else if (DLM == 1 && m_pos == m_pl + 1) begin
        e.en = 1'b1; e.data = 32'hB5983A1F;
      end else if (pay) begin
        e.en = 1'b1;
        e.data = v ? d : 32'h0;
        if (!v) m_urun++;
      end
      e.bs = (m_pos == 1) && (m_len > 0);
      if (m_len > 0 && m_len >= m_bp && m_pos == m_bp - 1) m_ovr = 1'b1;
      m_pos = (m_pos + 1 == m_per) ? 0 : m_pos + 1;
    end else begin
      pay = 1'b1;
      v = ($urandom_range(0, 1) == 1);
      e.en = 1'b1;
      e.data = v ? d : 32'h0;
    end
    e.urun = 32'(m_urun);
    e.ovr = m_ovr;
    if (e.bs) exp_bs++;
    if (pay && v) exp_acc++;
    pif.s_data = d;
    pif.s_valid = v;
    check("s_ready", 32'(pif.s_ready), 32'(pay));
    if (pif.s_ready && v) obs_acc++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("tx_data", tx_data, got.data);
    check("tx_burst_en", 32'(tx_en), 32'(got.en));
    check("burst_start", 32'(bs), 32'(got.bs));
    check("underrun_cnt", urun, got.urun);
    check("overrun", 32'(ovr), 32'(got.ovr));
    if (bs) obs_bs++;
    cur_slot++;
  endtask

  task automatic check_totals();
    check("burst_count", 32'(obs_bs), 32'(exp_bs));
    check("accepted_words", 32'(obs_acc), 32'(exp_acc));
  endtask

  initial begin
    tbl[0] = '{pl: 4,  bl: 8,  bp: 20, miss0: -1, miss1: -1, ncyc: 60, urun: 0, ovr: 1'b0};
    tbl[1] = '{pl: 2,  bl: 6,  bp: 30, miss0: 2,  miss1: 3,  ncyc: 32, urun: 2, ovr: 1'b0};
    tbl[2] = '{pl: 10, bl: 20, bp: 16, miss0: -1, miss1: -1, ncyc: 64, urun: 0, ovr: 1'b1};
    tbl[3] = '{pl: 0,  bl: 3,  bp: 6,  miss0: -1, miss1: -1, ncyc: 14, urun: 0, ovr: 1'b0};
    tbl[4] = '{pl: 0,  bl: 0,  bp: 5,  miss0: -1, miss1: -1, ncyc: 12, urun: 0, ovr: 1'b0};

    for (int t = 0; t < 5; t++) begin
      cur_test = t;
      reset_dut(tbl[t].pl, tbl[t].bl, tbl[t].bp);
      for (int j = 0; j < tbl[t].ncyc; j++) run_slot(0, tbl[t].miss0, tbl[t].miss1);
      check_totals();
      check("final_underrun", urun, tbl[t].urun);
      check("final_overrun", 32'(ovr), 32'(tbl[t].ovr));
    end

    // Burst length changed mid-payload: takes effect on the next burst only.
    cur_test = 5;
    reset_dut(4, 8, 20);
    for (int j = 0; j < 7; j++) run_slot(0, -1, -1);
    bl_v = 32'd4;
    for (int j = 7; j < 45; j++) run_slot(0, -1, -1);
    check_totals();
    check("bl_change_accepted", 32'(obs_acc), 32'd12);

    // b2bcontrol dropped mid-burst, continuous mode, return to burst mode, reset in continuous.
    cur_test = 6;
    reset_dut(4, 8, 20);
    for (int j = 0; j < 5; j++) run_slot(0, -1, -1);
    b2b = 1'b0;
    for (int j = 5; j < 14; j++) run_slot(0, -1, -1);
    for (int j = 14; j < 18; j++) run_slot(1, -1, -1);
    b2b = 1'b1;
    run_slot(1, -1, -1);
    m_pos = 0;
    for (int j = 19; j < 21; j++) run_slot(0, -1, -1);
    b2b = 1'b0;
    for (int j = 21; j < 33; j++) run_slot(0, -1, -1);
    for (int j = 33; j < 36; j++) run_slot(1, -1, -1);
    check_totals();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
